// File: rtl/display_scanner.sv
// Time-multiplexed driver for a multi-digit 7-segment display. One digit is
// presented per slot, with a double-buffered value, a guard interval and leading-zero blanking.
module display_scanner #(
    parameter int unsigned DIGITS        = 4,
    parameter int unsigned PRESCALE      = 50000,
    parameter int unsigned GUARD         = 16,
    parameter logic        SELECT_ACTIVE = 1'b0
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [4*DIGITS-1:0]        value_bus,
    input  logic                       load,
    input  logic                       blank_leading,
    output logic [3:0]                 data_bus,
    output logic [DIGITS-1:0]          digit_select,
    output logic [$clog2(DIGITS)-1:0]  digit_index,
    output logic                       frame_done,
    output logic                       busy_pending
);

    localparam int unsigned IW = $clog2(DIGITS);
    localparam int unsigned PW = $clog2(PRESCALE);
    localparam logic [PW-1:0] PRESCALE_LAST = PW'(PRESCALE - 1);
    localparam logic [PW-1:0] GUARD_CNT     = PW'(GUARD);
    localparam logic [IW-1:0] INDEX_LAST    = IW'(DIGITS - 1);

    // Bit k set when digits k..DIGITS-1 are all zero; digit 0 is always shown.
    function automatic logic [DIGITS-1:0] leading_zero_mask(input logic [4*DIGITS-1:0] v);
        logic [DIGITS-1:0] mask;
        logic              run;
        mask = '0;
        run  = 1'b1;
        for (int k = DIGITS - 1; k >= 1; k--) begin
            run     = run & (v[4*k +: 4] == 4'h0);
            mask[k] = run;
        end
        return mask;
    endfunction

    logic [PW-1:0]         prescale_r;
    logic [PW-1:0]         prescale_next_s;
    logic [IW-1:0]         index_r;
    logic [IW-1:0]         index_next_s;
    logic [4*DIGITS-1:0]   active_r;
    logic [4*DIGITS-1:0]   active_next_s;
    logic [4*DIGITS-1:0]   pending_r;
    logic [4*DIGITS-1:0]   pending_next_s;
    logic                  busy_r;
    logic                  busy_next_s;
    logic                  frame_done_r;
    logic [3:0]            data_r;
    logic [3:0]            data_next_s;
    logic [DIGITS-1:0]     select_r;
    logic [DIGITS-1:0]     select_next_s;
    logic [DIGITS-1:0]     blank_mask_s;
    logic                  tick_s;
    logic                  frame_tick_s;
    logic                  enable_s;

    // Slot timing, buffer transfer and next-state of the registered outputs.
    // Outputs are computed from next-state values so they line up with the prescaler.
    always_comb begin
        tick_s          = (prescale_r == PRESCALE_LAST);
        frame_tick_s    = tick_s && (index_r == INDEX_LAST);
        prescale_next_s = prescale_r + PW'(1);
        index_next_s    = index_r;
        active_next_s   = active_r;
        pending_next_s  = pending_r;
        busy_next_s     = busy_r;
        data_next_s     = 4'h0;
        select_next_s   = {DIGITS{~SELECT_ACTIVE}};

        if (tick_s) begin
            prescale_next_s = '0;
            if (index_r == INDEX_LAST) begin
                index_next_s = '0;
            end else begin
                index_next_s = index_r + IW'(1);
            end
        end else begin
            index_next_s = index_r;
        end

        if (frame_tick_s && busy_r) begin
            active_next_s = pending_r;
        end else begin
            active_next_s = active_r;
        end

        // A load on the boundary edge refills pending, so busy stays set.
        if (load) begin
            pending_next_s = value_bus;
            busy_next_s    = 1'b1;
        end else if (frame_tick_s) begin
            busy_next_s    = 1'b0;
        end else begin
            busy_next_s    = busy_r;
        end

        blank_mask_s = blank_leading ? leading_zero_mask(active_next_s) : '0;
        enable_s     = (prescale_next_s >= GUARD_CNT);

        for (int k = 0; k < DIGITS; k++) begin
            data_next_s      = data_next_s
                             | (active_next_s[4*k +: 4] & {4{index_next_s == IW'(k)}});
            select_next_s[k] = (enable_s && (index_next_s == IW'(k)) && !blank_mask_s[k])
                             ? SELECT_ACTIVE : ~SELECT_ACTIVE;
        end
    end

    // State and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prescale_r   <= '0;
            index_r      <= '0;
            active_r     <= '0;
            pending_r    <= '0;
            busy_r       <= 1'b0;
            frame_done_r <= 1'b0;
            data_r       <= 4'h0;
            select_r     <= {DIGITS{~SELECT_ACTIVE}};
        end else begin
            prescale_r   <= prescale_next_s;
            index_r      <= index_next_s;
            active_r     <= active_next_s;
            pending_r    <= pending_next_s;
            busy_r       <= busy_next_s;
            frame_done_r <= frame_tick_s;
            data_r       <= data_next_s;
            select_r     <= select_next_s;
        end
    end

    assign data_bus     = data_r;
    assign digit_select = select_r;
    assign digit_index  = index_r;
    assign frame_done   = frame_done_r;
    assign busy_pending = busy_r;

endmodule

// File: tb/tb_display_scanner.sv
// Directed, table-driven bench for display_scanner with DIGITS=4, PRESCALE=8, GUARD=2.
module tb_display_scanner;

    logic        clk;
    logic        rst_n;
    logic [15:0] value_bus;
    logic        load;
    logic        blank_leading;
    logic [3:0]  data_bus;
    logic [3:0]  digit_select;
    logic [1:0]  digit_index;
    logic        frame_done;
    logic        busy_pending;

    display_scanner #(
        .DIGITS(4), .PRESCALE(8), .GUARD(2), .SELECT_ACTIVE(1'b0)
    ) dut (
        .clk(clk), .rst_n(rst_n), .value_bus(value_bus), .load(load),
        .blank_leading(blank_leading), .data_bus(data_bus),
        .digit_select(digit_select), .digit_index(digit_index),
        .frame_done(frame_done), .busy_pending(busy_pending)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int          cyc;
        logic [1:0]  idx;
        logic [3:0]  data;
        logic [3:0]  sel;
        logic        fd;
        logic        busy;
        logic        do_load;
        logic [15:0] lval;
        logic        do_blank;
        logic        bval;
    } vec_t;

    vec_t vecs[$];
    int   cyc;
    int   checks;
    int   errors;
    int   fd_early;
    int   a_seen;

    function automatic vec_t mk(int c, logic [1:0] i, logic [3:0] d, logic [3:0] s,
                                logic f, logic b, logic dl, logic [15:0] lv,
                                logic db, logic bv);
        vec_t v;
        v.cyc = c; v.idx = i; v.data = d; v.sel = s; v.fd = f; v.busy = b;
        v.do_load = dl; v.lval = lv; v.do_blank = db; v.bval = bv;
        return v;
    endfunction

    task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cycle %0d: actual=%h expected=%h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
        load = 1'b0;
        cyc++;
        if (cyc < 40 && frame_done) fd_early++;
        if (data_bus == 4'hA) a_seen++;
    endtask

    task automatic check_all(input string tag, input logic [1:0] i, input logic [3:0] d,
                             input logic [3:0] s, input logic f, input logic b);
        check({tag, ".index"}, 16'(digit_index), 16'(i));
        check({tag, ".data"}, 16'(data_bus), 16'(d));
        check({tag, ".select"}, 16'(digit_select), 16'(s));
        check({tag, ".frame_done"}, 16'(frame_done), 16'(f));
        check({tag, ".busy"}, 16'(busy_pending), 16'(b));
    endtask

    initial begin
        checks = 0; errors = 0; fd_early = 0; a_seen = 0; cyc = 0;
        rst_n = 1'b1; load = 1'b0; value_bus = 16'h0000; blank_leading = 1'b0;

        // idle frames
        vecs.push_back(mk(  0, 2'd0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(  1, 2'd0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(  2, 2'd0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(  7, 2'd0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(  8, 2'd1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 10, 2'd1, 4'h0, 4'hD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 16, 2'd2, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 18, 2'd2, 4'h0, 4'hB, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 26, 2'd3, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 31, 2'd3, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 32, 2'd0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 33, 2'd0, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 34, 2'd0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        // single load mid-slot 1
        vecs.push_back(mk( 43, 2'd1, 4'h0, 4'hD, 1'b0, 1'b0, 1'b1, 16'h1234, 1'b0, 1'b0));
        vecs.push_back(mk( 44, 2'd1, 4'h0, 4'hD, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 63, 2'd3, 4'h0, 4'h7, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 64, 2'd0, 4'h4, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 66, 2'd0, 4'h4, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 74, 2'd1, 4'h3, 4'hD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 82, 2'd2, 4'h2, 4'hB, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk( 90, 2'd3, 4'h1, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        // two loads in one frame, last wins
        vecs.push_back(mk(100, 2'd0, 4'h4, 4'hE, 1'b0, 1'b0, 1'b1, 16'hAAAA, 1'b0, 1'b0));
        vecs.push_back(mk(101, 2'd0, 4'h4, 4'hE, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(110, 2'd1, 4'h3, 4'hD, 1'b0, 1'b1, 1'b1, 16'h0507, 1'b0, 1'b0));
        vecs.push_back(mk(127, 2'd3, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(128, 2'd0, 4'h7, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(130, 2'd0, 4'h7, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(138, 2'd1, 4'h0, 4'hD, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(146, 2'd2, 4'h5, 4'hB, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(154, 2'd3, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        // leading-zero blanking
        vecs.push_back(mk(160, 2'd0, 4'h7, 4'hF, 1'b1, 1'b0, 1'b1, 16'h0040, 1'b0, 1'b0));
        vecs.push_back(mk(170, 2'd1, 4'h0, 4'hD, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b1, 1'b1));
        vecs.push_back(mk(186, 2'd3, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(192, 2'd0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(194, 2'd0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(200, 2'd1, 4'h4, 4'hF, 1'b0, 1'b0, 1'b1, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(202, 2'd1, 4'h4, 4'hD, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(210, 2'd2, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(215, 2'd2, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(218, 2'd3, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(223, 2'd3, 4'h0, 4'hF, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(224, 2'd0, 4'h0, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(226, 2'd0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(234, 2'd1, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(242, 2'd2, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(250, 2'd3, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(251, 2'd3, 4'h0, 4'hF, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0));
        vecs.push_back(mk(252, 2'd3, 4'h0, 4'h7, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        // load coincident with the boundary tick
        vecs.push_back(mk(260, 2'd0, 4'h0, 4'hE, 1'b0, 1'b0, 1'b1, 16'h1111, 1'b0, 1'b0));
        vecs.push_back(mk(261, 2'd0, 4'h0, 4'hE, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(287, 2'd3, 4'h0, 4'h7, 1'b0, 1'b1, 1'b1, 16'h2222, 1'b0, 1'b0));
        vecs.push_back(mk(288, 2'd0, 4'h1, 4'hF, 1'b1, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(290, 2'd0, 4'h1, 4'hE, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(298, 2'd1, 4'h1, 4'hD, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(314, 2'd3, 4'h1, 4'h7, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(320, 2'd0, 4'h2, 4'hF, 1'b1, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(322, 2'd0, 4'h2, 4'hE, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));
        vecs.push_back(mk(338, 2'd2, 4'h2, 4'hB, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0, 1'b0));

        #2 rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check_all("reset", 2'd0, 4'h0, 4'hF, 1'b0, 1'b0);
        rst_n = 1'b1;
        cyc = 0;

        foreach (vecs[i]) begin
            while (cyc < vecs[i].cyc) step();
            check_all($sformatf("vec%0d", i), vecs[i].idx, vecs[i].data, vecs[i].sel,
                      vecs[i].fd, vecs[i].busy);
            if (vecs[i].do_load) begin
                value_bus = vecs[i].lval;
                load      = 1'b1;
            end
            if (vecs[i].do_blank) blank_leading = vecs[i].bval;
        end
        check("frame_done_count_first_40", 16'(fd_early), 16'd1);
        check("aaaa_never_shown", 16'(a_seen), 16'd0);

        // short asynchronous reset mid-slot 2, no clock edge while low
        while (cyc < 340) step();
        check("pre_reset.data", 16'(data_bus), 16'h2);
        rst_n = 1'b0;
        #2;
        check_all("async_reset", 2'd0, 4'h0, 4'hF, 1'b0, 1'b0);
        #2 rst_n = 1'b1;
        cyc = 0;
        step();
        check_all("post_reset_c1", 2'd0, 4'h0, 4'hF, 1'b0, 1'b0);
        step();
        check_all("post_reset_c2", 2'd0, 4'h0, 4'hE, 1'b0, 1'b0);
        while (cyc < 10) step();
        check_all("post_reset_c10", 2'd1, 4'h0, 4'hD, 1'b0, 1'b0);
        while (cyc < 32) step();
        check_all("post_reset_c32", 2'd0, 4'h0, 4'hF, 1'b1, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/display_scanner.md
Name: display_scanner

Overview:
- Time-multiplexes a DIGITS-wide packed hex/BCD value onto a single 7-segment decoder stage.
- Sits directly upstream of the segment decoder:
  - drives the decoder's 4-bit data_bus input one digit at a time;
  - drives the matching digit-enable line of the physical display.
- Provides a double-buffered load, a per-slot anti-ghosting guard interval and optional leading-zero blanking.

Parameters:
- DIGITS, 4, number of display digits (2..8).
- PRESCALE, 50000, clock cycles per digit slot (>= GUARD+2).
- GUARD, 16, cycles at the start of each slot during which no digit is enabled (0 allowed).
- SELECT_ACTIVE, 1'b0, active level of digit_select (0 = common-anode PNP drivers).

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- value_bus  input  4*DIGITS  packed digits; [3:0] = digit 0 (least significant, rightmost).
- load  input  1  single-cycle strobe; captures value_bus.
- blank_leading  input  1  1 = suppress leading zero digits.
- data_bus  output  4  nibble of the currently scanned digit, to the segment decoder.
- digit_select  output  DIGITS  one-hot (at SELECT_ACTIVE level) digit enable.
- digit_index  output  clog2(DIGITS)  index of the current slot.
- frame_done  output  1  one-cycle pulse when the last slot ends.
- busy_pending  output  1  a loaded value is waiting for the frame boundary.

Behaviour:
- Clock and reset:
  - Single clock domain.
  - rst_n low asynchronously clears all state: prescaler = 0, digit_index = 0, active and pending registers = 0, busy_pending = 0, frame_done = 0, data_bus = 0, digit_select = all inactive (~SELECT_ACTIVE).
- Registered outputs: all outputs come straight from flops.
- Prescaler:
  - Counts 0..PRESCALE-1, then wraps.
  - Terminal count (PRESCALE-1) is the slot tick.
- Slot advance: on the tick edge digit_index advances, wrapping DIGITS-1 -> 0.
- Frame boundary: the tick with digit_index = DIGITS-1.
  - frame_done = 1 for exactly the following cycle.
  - If busy_pending = 1: active <= pending and busy_pending <= 0 on the same edge.
- Load:
  - load = 1 captures value_bus into pending and sets busy_pending on the next edge.
  - A later load before the boundary overwrites pending; last write wins.
  - load coincident with the boundary tick: the previously pending value (if any) transfers to active, the new value goes to pending, and busy_pending stays 1.
- Guard interval:
  - While prescaler < GUARD, digit_select is all inactive.
  - Otherwise digit_select asserts only bit digit_index, unless that digit is blanked.
- data_bus: always equals the active nibble for digit_index, including during guard and blanking. It updates on the same edge digit_index changes.
- Leading-zero blanking, when blank_leading = 1:
  - Digit k is blanked if every active nibble from k up to DIGITS-1 is 0.
  - Digit 0 is never blanked, so a value of 0 shows "0".
  - Blanking is evaluated on the active register only; pending has no effect until transfer.
- Mode changes: blank_leading changes take effect from the next cycle. No resynchronisation of slot timing.
- Reset mid-frame: immediate return to reset state. First slot restarts at index 0 with a full guard.
- Scan period: frame period = DIGITS*PRESCALE cycles. No stall input; scanning is free-running.

Test Plan:
(Bench params: DIGITS=4, PRESCALE=8, GUARD=2, SELECT_ACTIVE=0.)
- Reset, then 40 idle cycles:
  - digit_index sequences 0,1,2,3,0 with 8 cycles each;
  - data_bus = 0;
  - digit_select = 4'b1110 in cycles 2..7 of slot 0;
  - frame_done pulses once at cycle 32.
- load with value_bus = 16'h1234 mid-slot 1:
  - busy_pending = 1 until the frame boundary;
  - next frame shows data_bus 4,3,2,1 for indices 0..3;
  - busy_pending returns to 0 with the frame_done pulse.
- Two loads, 16'hAAAA then 16'h0507, in the same frame: next frame shows 7,0,5,0; 16'hAAAA is never displayed.
- blank_leading = 1 with active 16'h0040:
  - digits 3 and 2 keep digit_select = 4'b1111 throughout;
  - digits 1 and 0 enable normally.
  - With active 16'h0000, only digit 0 enables.
- load asserted exactly on the boundary tick with a prior pending 16'h1111 and new 16'h2222:
  - next frame shows 1111;
  - busy_pending stays 1;
  - the following frame shows 2222.
- rst_n pulsed low mid-slot 2 for less than one clock period: all outputs clear immediately without a clock edge; active = 0; scanning resumes at index 0 with guard.
